// File: rtl/msdf_add_ctrl_if.sv
// Operand/result handshake bundle between a requester and the MSDF add controller.
// Digit 0 (most significant) sits in the top DW bits of each vector.
interface msdf_add_ctrl_if #(
  parameter int NDIG = 4,
  parameter int DW   = 5
);
  logic                in_valid;
  logic                in_ready;
  logic [NDIG*DW-1:0]  x_vec;
  logic [NDIG*DW-1:0]  y_vec;
  logic                out_valid;
  logic                out_ready;
  logic [NDIG*DW-1:0]  s_vec;

  modport master (
    output in_valid, x_vec, y_vec, out_ready,
    input  in_ready, out_valid, s_vec
  );

  modport slave (
    input  in_valid, x_vec, y_vec, out_ready,
    output in_ready, out_valid, s_vec
  );
endinterface

// File: rtl/msdf_add_ctrl.sv
// Sequences one NDIG-digit operand pair through an online (MSD-first) adder
// with DELAY cycles of online delay and collects the result digits.
module msdf_add_ctrl #(
  parameter int NDIG  = 4,
  parameter int DELAY = 2,
  parameter int DW    = 5
) (
  input  logic          clk,
  input  logic          reset,
  msdf_add_ctrl_if.slave bus,
  output logic [DW-1:0] add_x,
  output logic [DW-1:0] add_y,
  output logic          add_rst,
  input  logic [DW-1:0] add_s,
  output logic          busy
);

  localparam int KW = $clog2(NDIG + DELAY + 1);
  localparam logic [KW-1:0] KLAST = KW'(NDIG + DELAY - 1);

  typedef enum logic [1:0] {IDLE, CLR, STREAM, DONE} state_t;

  state_t             state, nxt;
  logic [KW-1:0]      k;
  logic [NDIG*DW-1:0] xr, yr, sr;
  logic [DW-1:0]      dx, dy;
  logic               in_ready_c, out_valid_c;

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.s_vec     = sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      k     <= '0;
      xr    <= '0;
      yr    <= '0;
      sr    <= '0;
    end else begin
      state <= nxt;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            xr <= bus.x_vec;
            yr <= bus.y_vec;
          end
        end
        CLR: k <= '0;
        STREAM: begin
          // k stops at NDIG+DELAY, which still fits in KW bits, so it never wraps
          k <= k + 1'b1;
          for (int i = 0; i < NDIG; i++) begin
            if (k == KW'(i + DELAY))
              sr[(NDIG-1-i)*DW +: DW] <= add_s;
          end
        end
        default: ;
      endcase
    end
  end

  // Digit k of each latched operand; past the last digit the adder is fed zeros.
  always_comb begin
    dx = '0;
    dy = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (k == KW'(i)) begin
        dx = xr[(NDIG-1-i)*DW +: DW];
        dy = yr[(NDIG-1-i)*DW +: DW];
      end
    end
  end

  always_comb begin
    nxt         = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    add_rst     = 1'b0;
    add_x       = '0;
    add_y       = '0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy       = 1'b0;
        in_ready_c = 1'b1;
        if (bus.in_valid) nxt = CLR;
      end
      CLR: begin
        add_rst = 1'b1;
        nxt     = STREAM;
      end
      STREAM: begin
        add_x = dx;
        add_y = dy;
        if (k == KLAST) nxt = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Reset overrides everything and holds the adder in reset as well.
    if (reset) begin
      nxt         = IDLE;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      busy        = 1'b0;
      add_x       = '0;
      add_y       = '0;
      add_rst     = 1'b1;
    end
  end

endmodule

// File: tb/tb_msdf_add_ctrl.sv
// Directed bench for msdf_add_ctrl with a stub adder: add_s is add_x+add_y
// delayed by two cycles, and the delay line is cleared by add_rst.
module tb_msdf_add_ctrl;
  localparam int NDIG = 4, DELAY = 2, DW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] add_x, add_y, add_s;
  logic          add_rst, busy;
  logic [DW-1:0] p0, p1;
  int            cyc = 0;

  int nvec = 0;
  int nmis = 0;

  int            got_lat, rst_cnt, t_acc;
  logic [19:0]   got_s;
  logic [4:0]    axs [6];

  msdf_add_ctrl_if #(.NDIG(NDIG), .DW(DW)) bus ();

  msdf_add_ctrl #(.NDIG(NDIG), .DELAY(DELAY), .DW(DW)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .add_x(add_x), .add_y(add_y), .add_rst(add_rst), .add_s(add_s), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (add_rst) begin
      p0 <= '0;
      p1 <= '0;
    end else begin
      p0 <= add_x + add_y;
      p1 <= p0;
    end
  end
  assign add_s = p1;

  function automatic logic [19:0] pack4(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offers one operand pair and follows it to its DONE cycle. The accept cycle
  // is the IDLE cycle in which in_valid is seen; latency is counted from it.
  // With keep set, in_valid stays high carrying junk operands that must be ignored.
  task automatic run_op(input logic [19:0] x, input logic [19:0] y, input bit keep);
    int n;
    got_lat = -1;
    got_s   = 'x;
    rst_cnt = 0;
    for (int i = 0; i < 6; i++) axs[i] = 'x;
    bus.x_vec    = x;
    bus.y_vec    = y;
    bus.in_valid = 1'b1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 30) begin
      tick;
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      bus.in_valid = 1'b0;
      return;
    end
    t_acc = cyc;
    tick;
    if (keep) begin
      bus.x_vec = ~x;
      bus.y_vec = ~y;
    end else begin
      bus.in_valid = 1'b0;
    end
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 30) begin
      if (add_rst === 1'b1) rst_cnt++;
      if (cyc - t_acc >= 2 && cyc - t_acc <= 7) axs[cyc - t_acc - 2] = add_x;
      tick;
      n++;
    end
    if (bus.out_valid === 1'b1) begin
      got_lat = cyc - t_acc;
      got_s   = bus.s_vec;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.x_vec = '0;
    bus.y_vec = '0;
    tick; tick; tick;
    nvec++; if (bus.in_ready !== 1'b0) begin nmis++; $display("[TB] FAIL rst_in_ready: got %b expected 0", bus.in_ready); end
    nvec++; if (bus.out_valid !== 1'b0) begin nmis++; $display("[TB] FAIL rst_out_valid: got %b expected 0", bus.out_valid); end
    nvec++; if (busy !== 1'b0) begin nmis++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    nvec++; if (add_rst !== 1'b1) begin nmis++; $display("[TB] FAIL rst_add_rst: got %b expected 1", add_rst); end
    nvec++; if ({add_x, add_y} !== 10'd0) begin nmis++; $display("[TB] FAIL rst_add_xy: got %h expected 0", {add_x, add_y}); end
    nvec++; if (bus.s_vec !== 20'd0) begin nmis++; $display("[TB] FAIL rst_s_vec: got %h expected 0", bus.s_vec); end
    reset = 1'b0;
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nmis++; $display("[TB] FAIL post_rst_in_ready: got %b expected 1", bus.in_ready); end
    nvec++; if (add_rst !== 1'b0) begin nmis++; $display("[TB] FAIL post_rst_add_rst: got %b expected 0", add_rst); end
  endtask

  task automatic test_basic;
    logic [4:0] ex [6];
    ex = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd0, 5'd0};
    bus.out_ready = 1'b1;
    run_op(pack4(1, 2, 3, 4), pack4(4, 3, 2, 1), 1'b0);
    nvec++; if (got_lat !== 8) begin nmis++; $display("[TB] FAIL basic_latency: got %0d expected 8", got_lat); end
    nvec++; if (rst_cnt !== 1) begin nmis++; $display("[TB] FAIL basic_add_rst_pulses: got %0d expected 1", rst_cnt); end
    for (int i = 0; i < 6; i++) begin
      nvec++; if (axs[i] !== ex[i]) begin nmis++; $display("[TB] FAIL basic_add_x[%0d]: got %h expected %h", i, axs[i], ex[i]); end
    end
    nvec++; if (got_s !== pack4(5, 5, 5, 5)) begin nmis++; $display("[TB] FAIL basic_s_vec: got %h expected %h", got_s, pack4(5, 5, 5, 5)); end
    tick;
    nvec++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin nmis++; $display("[TB] FAIL basic_single_done: got out_valid=%b in_ready=%b expected 0/1", bus.out_valid, bus.in_ready); end
    nvec++; if (bus.s_vec !== pack4(5, 5, 5, 5)) begin nmis++; $display("[TB] FAIL basic_s_hold: got %h expected %h", bus.s_vec, pack4(5, 5, 5, 5)); end
  endtask

  task automatic test_wrap;
    bus.out_ready = 1'b1;
    run_op(pack4(-9, 9, -9, 9), pack4(-1, -9, 0, 9), 1'b0);
    nvec++; if (got_s !== 20'b10110_00000_10111_10010) begin nmis++; $display("[TB] FAIL wrap_s_vec: got %b expected 10110000001011110010", got_s); end
    nvec++; if (got_lat !== 8) begin nmis++; $display("[TB] FAIL wrap_latency: got %0d expected 8", got_lat); end
    tick;
  endtask

  task automatic test_stall;
    logic [19:0] s1;
    s1 = pack4(4, 3, 0, 11);
    bus.out_ready = 1'b0;
    run_op(pack4(3, -2, 7, 0), pack4(1, 5, -7, 11), 1'b0);
    nvec++; if (got_s !== s1) begin nmis++; $display("[TB] FAIL stall_s1: got %h expected %h", got_s, s1); end
    bus.in_valid = 1'b1;
    bus.x_vec = pack4(6, 6, 6, 6);
    bus.y_vec = pack4(-1, -2, -3, -4);
    for (int i = 0; i < 5; i++) begin
      nvec++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.s_vec !== s1) begin
        nmis++; $display("[TB] FAIL stall_hold[%0d]: got ov=%b ir=%b s=%h expected 1/0/%h", i, bus.out_valid, bus.in_ready, bus.s_vec, s1);
      end
      tick;
    end
    bus.out_ready = 1'b1;
    #1;
    nvec++; if (bus.out_valid !== 1'b1) begin nmis++; $display("[TB] FAIL stall_release: got %b expected 1", bus.out_valid); end
    tick;
    nvec++; if (bus.in_ready !== 1'b1 || bus.s_vec !== s1) begin nmis++; $display("[TB] FAIL stall_idle: got ir=%b s=%h expected 1/%h", bus.in_ready, bus.s_vec, s1); end
    run_op(pack4(6, 6, 6, 6), pack4(-1, -2, -3, -4), 1'b0);
    nvec++; if (got_s !== pack4(5, 4, 3, 2)) begin nmis++; $display("[TB] FAIL stall_s2: got %h expected %h", got_s, pack4(5, 4, 3, 2)); end
    nvec++; if (got_lat !== 8) begin nmis++; $display("[TB] FAIL stall_latency2: got %0d expected 8", got_lat); end
    tick;
  endtask

  task automatic test_abort;
    int ov_seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_vec = pack4(5, 6, 7, 1);
    bus.y_vec = pack4(2, 2, 2, 2);
    #1;
    nvec++; if (bus.in_ready !== 1'b1) begin nmis++; $display("[TB] FAIL abort_ready: got %b expected 1", bus.in_ready); end
    tick;
    bus.in_valid = 1'b0;
    tick; tick; tick; tick;
    nvec++; if (add_x !== 5'd1 || busy !== 1'b1) begin nmis++; $display("[TB] FAIL abort_k3_digit: got add_x=%h busy=%b expected 01/1", add_x, busy); end
    reset = 1'b1;
    #1;
    nvec++; if ({bus.in_ready, bus.out_valid, busy, add_rst} !== 4'b0001 || {add_x, add_y} !== 10'd0) begin
      nmis++; $display("[TB] FAIL abort_rst_outputs: got ir/ov/busy/arst=%b%b%b%b xy=%h expected 0001/0", bus.in_ready, bus.out_valid, busy, add_rst, {add_x, add_y});
    end
    tick;
    reset = 1'b0;
    #1;
    nvec++; if (bus.in_ready !== 1'b1 || busy !== 1'b0 || bus.s_vec !== 20'd0) begin
      nmis++; $display("[TB] FAIL abort_idle: got ir=%b busy=%b s=%h expected 1/0/0", bus.in_ready, busy, bus.s_vec);
    end
    ov_seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.out_valid === 1'b1) ov_seen++;
      tick;
    end
    nvec++; if (ov_seen !== 0) begin nmis++; $display("[TB] FAIL abort_no_out_valid: got %0d cycles expected 0", ov_seen); end
    run_op(pack4(1, 1, 1, 1), pack4(2, 2, 2, 2), 1'b0);
    nvec++; if (got_s !== pack4(3, 3, 3, 3)) begin nmis++; $display("[TB] FAIL abort_recover_s: got %h expected %h", got_s, pack4(3, 3, 3, 3)); end
    nvec++; if (got_lat !== 8) begin nmis++; $display("[TB] FAIL abort_recover_latency: got %0d expected 8", got_lat); end
    tick;
  endtask

  task automatic test_back_to_back;
    logic [19:0] xs [3], ys [3], es [3];
    int prev_t;
    xs = '{pack4(1, 2, 3, 4), pack4(7, -8, 0, 3), pack4(2, 0, -5, 6)};
    ys = '{pack4(1, 1, 1, 1), pack4(7, -8, 15, -3), pack4(3, 4, 5, -6)};
    es = '{pack4(2, 3, 4, 5), pack4(14, -16, 15, 0), pack4(5, 4, 0, 0)};
    bus.out_ready = 1'b1;
    prev_t = -1;
    for (int i = 0; i < 3; i++) begin
      run_op(xs[i], ys[i], 1'b1);
      nvec++; if (got_lat !== 8 || rst_cnt !== 1) begin nmis++; $display("[TB] FAIL b2b_timing[%0d]: got lat=%0d rst=%0d expected 8/1", i, got_lat, rst_cnt); end
      nvec++; if (got_s !== es[i]) begin nmis++; $display("[TB] FAIL b2b_s_vec[%0d]: got %h expected %h", i, got_s, es[i]); end
      if (i > 0) begin
        nvec++; if (t_acc - prev_t !== 9) begin nmis++; $display("[TB] FAIL b2b_gap[%0d]: got %0d expected 9", i, t_acc - prev_t); end
      end
      prev_t = t_acc;
    end
    bus.in_valid = 1'b0;
    tick;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_abort;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/msdf_add_ctrl.md
MSDF_ADD_CTRL -- requirements
Module: msdf_add_ctrl

Interface
REQ-001 Parameter NDIG, default 4: number of operand and result digits per operation.
REQ-002 Parameter DELAY, default 2: online delay of the attached riadd instance, in cycles.
REQ-003 Parameter DW, default 5: signed digit width in bits, two's complement.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  operand pair offered.
REQ-007 in_ready  output  1  controller accepts an operand pair this cycle.
REQ-008 x_vec  input  NDIG*DW  operand X digits; digit 0 (most significant) in bits [NDIG*DW-1 -: DW].
REQ-009 y_vec  input  NDIG*DW  operand Y digits, same packing as x_vec.
REQ-010 add_x  output  DW  digit driven to the adder x_j2 input.
REQ-011 add_y  output  DW  digit driven to the adder y_j2 input.
REQ-012 add_rst  output  1  reset driven to the adder's reset input.
REQ-013 add_s  input  DW  adder s_j output.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer accepts the result.
REQ-016 s_vec  output  NDIG*DW  result digits, same packing as x_vec.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, CLR, STREAM and DONE.
REQ-019 IDLE: in_ready=1; when in_valid=1, latch x_vec and y_vec into internal registers and go to CLR.
REQ-020 CLR: add_rst=1 for exactly one cycle, digit counter k cleared to 0, then go to STREAM.
REQ-021 add_rst SHALL be 0 in every state except CLR, and 1 while reset is high.
REQ-022 STREAM lasts exactly NDIG+DELAY cycles, k=0..NDIG+DELAY-1.
REQ-023 STREAM: for k<NDIG, add_x/add_y = latched digit k of X/Y; for k>=NDIG, add_x=add_y=0.
REQ-024 STREAM: when k>=DELAY, capture add_s into result digit k-DELAY on that cycle's posedge.
REQ-025 After the cycle with k=NDIG+DELAY-1, go to DONE.
REQ-026 add_x and add_y SHALL be 0 in every state except STREAM.
REQ-027 DONE: out_valid=1, s_vec stable; when out_ready=1, go to IDLE next cycle.
REQ-028 Operation latency: in_valid accept edge to out_valid high = NDIG+DELAY+2 cycles.
REQ-029 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored, with latched operands unchanged.
REQ-030 out_valid with out_ready already high SHALL complete in one DONE cycle.
REQ-031 Back-to-back: a new operand pair is accepted in the IDLE cycle directly after DONE; there is no combinational in_ready path from out_ready.
REQ-032 s_vec SHALL hold its value until the next STREAM capture overwrites it.
REQ-033 k SHALL be sized clog2(NDIG+DELAY+1) bits and SHALL NOT wrap within an operation.

Reset
REQ-034 While reset=1, at each posedge: state=IDLE, k=0, operand and result registers cleared to 0.
REQ-035 While reset=1: in_ready=0, out_valid=0, busy=0, add_x=add_y=0, add_rst=1.
REQ-036 A reset asserted in CLR, STREAM or DONE SHALL abort the operation with no out_valid pulse.
REQ-037 After such an abort the controller SHALL accept a new operand pair normally.
REQ-038 First cycle after reset deasserts: IDLE, in_ready=1.

Verification
(Bench uses NDIG=4, DELAY=2, DW=5 and a stub adder: add_s = add_x+add_y from DELAY cycles earlier, pipeline cleared by add_rst.)
REQ-039 X=(1,2,3,4), Y=(4,3,2,1), out_ready=1 -> add_x sequence 1,2,3,4,0,0; s_vec=(5,5,5,5); out_valid exactly 8 cycles after accept.
REQ-040 X=(-9,9,-9,9), Y=(-1,-9,0,9) -> s_vec=(-10,0,-9,18) as wrapped DW-bit values; exact bit pattern checked.
REQ-041 out_ready held 0 for 5 cycles in DONE, in_valid=1 with new operands throughout -> s_vec stable, in_ready=0, second operation starts only after out_ready=1.
REQ-042 Reset pulsed at STREAM k=3 -> next cycle IDLE, all outputs at reset values, no out_valid; then X=(1,1,1,1), Y=(2,2,2,2) -> s_vec=(3,3,3,3).
REQ-043 Three back-to-back operations with in_valid and out_ready tied high -> every operation's latency is 8 cycles, add_rst pulses exactly once per operation, and every s_vec is correct.
